// File: rtl/imm_pkg.sv
// ============================================================================
// imm_pkg : RV64 opcode and immediate-format encodings shared by imm_gen_pipe
// Rev 1.0
// ============================================================================
`default_nettype none

package imm_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  function automatic logic is_shift(input logic [2:0] funct3);
    return (funct3 == F3_SLL) || (funct3 == F3_SRX);
  endfunction

endpackage

`default_nettype wire

// File: rtl/imm_decode.sv
// ============================================================================
// imm_decode : combinational RV64 immediate decode (I/S/B/U/J/SHAMT)
// Rev 1.0
// ============================================================================
`default_nettype none

module imm_decode
  import imm_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter bit SHIFT_B = 1'b1
) (
  input  logic [31:0]       inst_i,
  output logic [DATA_W-1:0] imm_o,
  output logic [2:0]        fmt_o,
  output logic              illegal_o
);

  logic [6:0]        w_opcode;
  logic [2:0]        w_funct3;
  logic [31:0]       w_raw;
  logic [DATA_W-1:0] w_ext;

  assign w_opcode = inst_i[6:0];
  assign w_funct3 = inst_i[14:12];

  always_comb begin
    w_raw     = '0;
    fmt_o     = FMT_NONE;
    illegal_o = 1'b0;
    case (w_opcode)
      OP_LOAD, OP_JALR, OP_SYSTEM: begin
        w_raw = {{20{inst_i[31]}}, inst_i[31:20]};
        fmt_o = FMT_I;
      end
      OP_IMM: begin
        if (is_shift(w_funct3)) begin
          w_raw = {26'd0, inst_i[25:20]};
          fmt_o = FMT_SHAMT;
        end else begin
          w_raw = {{20{inst_i[31]}}, inst_i[31:20]};
          fmt_o = FMT_I;
        end
      end
      OP_IMM32: begin
        // Word shifts only have a 5-bit shamt; bit 25 is not part of it.
        if (is_shift(w_funct3)) begin
          w_raw = {27'd0, inst_i[24:20]};
          fmt_o = FMT_SHAMT;
        end else begin
          w_raw = {{20{inst_i[31]}}, inst_i[31:20]};
          fmt_o = FMT_I;
        end
      end
      OP_STORE: begin
        w_raw = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
        fmt_o = FMT_S;
      end
      OP_BRANCH: begin
        w_raw = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
        fmt_o = FMT_B;
      end
      OP_LUI, OP_AUIPC: begin
        w_raw = {inst_i[31:12], 12'd0};
        fmt_o = FMT_U;
      end
      OP_JAL: begin
        w_raw = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
        fmt_o = FMT_J;
      end
      default: illegal_o = 1'b1;
    endcase
  end

  // Replication count stays >= 1 even when DATA_W == 32.
  assign w_ext = {{(DATA_W-31){w_raw[31]}}, w_raw[30:0]};

  always_comb begin
    imm_o = w_ext;
    if (!SHIFT_B && ((fmt_o == FMT_B) || (fmt_o == FMT_J))) begin
      imm_o = {w_ext[DATA_W-1], w_ext[DATA_W-1:1]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/imm_gen_pipe.sv
// ============================================================================
// imm_gen_pipe : pipelined immediate generator, valid/ready with 2-entry skid
// Rev 1.0
// ============================================================================
`default_nettype none

module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int INST_W  = 32,
  parameter int DATA_W  = 64,
  parameter bit SHIFT_B = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [INST_W-1:0] i_inst,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_imm,
  output logic [2:0]        o_fmt,
  output logic              o_illegal
);

  if (INST_W != 32) begin : g_bad_inst_w
    $error("imm_gen_pipe: INST_W must be 32");
  end
  if (DATA_W < 32) begin : g_bad_data_w
    $error("imm_gen_pipe: DATA_W must be >= 32");
  end

  logic [DATA_W-1:0] w_dec_imm;
  logic [2:0]        w_dec_fmt;
  logic              w_dec_ill;

  imm_decode #(
    .DATA_W  (DATA_W),
    .SHIFT_B (SHIFT_B)
  ) u_decode (
    .inst_i    (i_inst[31:0]),
    .imm_o     (w_dec_imm),
    .fmt_o     (w_dec_fmt),
    .illegal_o (w_dec_ill)
  );

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_imm_q,   out_imm_d;
  logic [2:0]        out_fmt_q,   out_fmt_d;
  logic              out_ill_q,   out_ill_d;
  logic              skid_full_q, skid_full_d;
  logic [DATA_W-1:0] skid_imm_q,  skid_imm_d;
  logic [2:0]        skid_fmt_q,  skid_fmt_d;
  logic              skid_ill_q,  skid_ill_d;

  logic w_accept;
  logic w_drain;

  assign w_accept = i_valid && !skid_full_q;
  assign w_drain  = out_valid_q && i_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_imm_d   = out_imm_q;
    out_fmt_d   = out_fmt_q;
    out_ill_d   = out_ill_q;
    skid_full_d = skid_full_q;
    skid_imm_d  = skid_imm_q;
    skid_fmt_d  = skid_fmt_q;
    skid_ill_d  = skid_ill_q;
    if (w_drain) begin
      // With SKID full o_ready is low, so no accept can coincide here.
      if (skid_full_q) begin
        out_imm_d   = skid_imm_q;
        out_fmt_d   = skid_fmt_q;
        out_ill_d   = skid_ill_q;
        skid_full_d = 1'b0;
      end else if (w_accept) begin
        out_imm_d = w_dec_imm;
        out_fmt_d = w_dec_fmt;
        out_ill_d = w_dec_ill;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (w_accept) begin
      if (!out_valid_q) begin
        out_valid_d = 1'b1;
        out_imm_d   = w_dec_imm;
        out_fmt_d   = w_dec_fmt;
        out_ill_d   = w_dec_ill;
      end else begin
        skid_full_d = 1'b1;
        skid_imm_d  = w_dec_imm;
        skid_fmt_d  = w_dec_fmt;
        skid_ill_d  = w_dec_ill;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_valid_q <= 1'b0;
      out_imm_q   <= '0;
      out_fmt_q   <= FMT_NONE;
      out_ill_q   <= 1'b0;
      skid_full_q <= 1'b0;
      skid_imm_q  <= '0;
      skid_fmt_q  <= FMT_NONE;
      skid_ill_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_imm_q   <= out_imm_d;
      out_fmt_q   <= out_fmt_d;
      out_ill_q   <= out_ill_d;
      skid_full_q <= skid_full_d;
      skid_imm_q  <= skid_imm_d;
      skid_fmt_q  <= skid_fmt_d;
      skid_ill_q  <= skid_ill_d;
    end
  end

  assign o_ready   = !skid_full_q;
  assign o_valid   = out_valid_q;
  assign o_imm     = out_imm_q;
  assign o_fmt     = out_fmt_q;
  assign o_illegal = out_ill_q;

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
// ============================================================================
// tb_imm_gen_pipe : directed + random bench with queue-based reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_imm_gen_pipe;

  typedef struct packed {
    logic [63:0] imm_b1;
    logic [63:0] imm_b0;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b0;
  logic [31:0] i_inst = '0;
  logic        o_ready, o_valid, o_illegal;
  logic [63:0] o_imm;
  logic [2:0]  o_fmt;
  logic        h_ready, h_valid, h_illegal;
  logic [63:0] h_imm;
  logic [2:0]  h_fmt;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.INST_W(32), .DATA_W(64), .SHIFT_B(1'b1)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_inst(i_inst), .o_valid(o_valid), .i_ready(i_ready),
    .o_imm(o_imm), .o_fmt(o_fmt), .o_illegal(o_illegal)
  );

  imm_gen_pipe #(.INST_W(32), .DATA_W(64), .SHIFT_B(1'b0)) dut_h (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(h_ready),
    .i_inst(i_inst), .o_valid(h_valid), .i_ready(i_ready),
    .o_imm(h_imm), .o_fmt(h_fmt), .o_illegal(h_illegal)
  );

  function automatic exp_t ref_dec(input logic [31:0] in);
    exp_t   e;
    longint v;
    logic [6:0] op;
    logic [2:0] f3;
    op = in[6:0];
    f3 = in[14:12];
    v  = 0;
    e.fmt = 3'd0;
    e.ill = 1'b0;
    if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
      v = longint'(in[25:20]); e.fmt = 3'd6;
    end else if (op == 7'h1B && (f3 == 3'd1 || f3 == 3'd5)) begin
      v = longint'(in[24:20]); e.fmt = 3'd6;
    end else if (op == 7'h03 || op == 7'h13 || op == 7'h1B || op == 7'h67 || op == 7'h73) begin
      v = longint'($signed(in[31:20])); e.fmt = 3'd1;
    end else if (op == 7'h23) begin
      v = longint'($signed({in[31:25], in[11:7]})); e.fmt = 3'd2;
    end else if (op == 7'h63) begin
      v = longint'($signed({in[31], in[7], in[30:25], in[11:8], 1'b0})); e.fmt = 3'd3;
    end else if (op == 7'h37 || op == 7'h17) begin
      v = longint'($signed({in[31:12], 12'd0})); e.fmt = 3'd4;
    end else if (op == 7'h6F) begin
      v = longint'($signed({in[31], in[19:12], in[20], in[30:21], 1'b0})); e.fmt = 3'd5;
    end else begin
      e.ill = 1'b1;
    end
    e.imm_b1 = v;
    e.imm_b0 = (e.fmt == 3'd3 || e.fmt == 3'd5) ? v / 2 : v;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called mid-cycle: checks the DUT against the in-flight queue, then
  // applies this cycle's handshakes to the queue.
  task automatic model_step();
    int   sz;
    exp_t e;
    sz = q.size();
    chk("o_ready", o_ready, sz < 2);
    chk("h_ready", h_ready, sz < 2);
    chk("o_valid", o_valid, sz > 0);
    chk("h_valid", h_valid, sz > 0);
    if (sz > 0) begin
      e = q[0];
      chk("o_imm", o_imm, e.imm_b1);
      chk("h_imm", h_imm, e.imm_b0);
      chk("o_fmt", o_fmt, e.fmt);
      chk("o_illegal", o_illegal, e.ill);
      chk("h_fmt", h_fmt, e.fmt);
      if (i_ready) void'(q.pop_front());
    end
    if (i_valid && sz < 2) q.push_back(ref_dec(i_inst));
  endtask

  task automatic cycle(input logic v, input logic [31:0] in, input logic r);
    i_valid = v; i_inst = in; i_ready = r;
    @(negedge clk);
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic directed(input logic [31:0] in, input logic [63:0] e1,
                          input logic [63:0] e0, input logic [2:0] f, input logic il);
    cycle(1'b1, in, 1'b1);
    i_valid = 1'b0; i_ready = 1'b1;
    @(negedge clk);
    chk("dir_valid", o_valid, 1'b1);
    chk("dir_imm", o_imm, e1);
    chk("dir_imm_b0", h_imm, e0);
    chk("dir_fmt", o_fmt, f);
    chk("dir_illegal", o_illegal, il);
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    @(posedge clk); #1;
    i_rst = 1'b0;
    q.delete();
    @(negedge clk);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_imm", o_imm, 64'd0);
    chk("rst_fmt", o_fmt, 3'd0);
    chk("rst_illegal", o_illegal, 1'b0);
    @(posedge clk); #1;
  endtask

  localparam logic [6:0] OPS [11] = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h73,
                                      7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h13};

  initial begin
    logic [31:0] r;
    @(posedge clk); #1;
    do_reset();

    directed(32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
    directed(32'hFE112E23, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0);
    directed(32'h03F11093, 64'd63, 64'd63, 3'd6, 1'b0);
    directed(32'hFE000CE3, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0);
    directed(32'h800000B7, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0);
    directed(32'h0000007F, 64'd0, 64'd0, 3'd0, 1'b1);

    // Backpressure: three offered while stalled, only two fit.
    cycle(1'b1, 32'hFFF00093, 1'b0);
    cycle(1'b1, 32'hFE112E23, 1'b0);
    cycle(1'b1, 32'h03F11093, 1'b0);
    chk("bp_ready_low", o_ready, 1'b0);
    cycle(1'b1, 32'h03F11093, 1'b0);
    cycle(1'b1, 32'h03F11093, 1'b1);
    cycle(1'b1, 32'h03F11093, 1'b1);
    for (int k = 0; k < 4; k++) cycle(1'b0, 32'd0, 1'b1);

    // Reset with OUT and SKID both occupied.
    cycle(1'b1, 32'h800000B7, 1'b0);
    cycle(1'b1, 32'hFE000CE3, 1'b0);
    chk("full_before_rst", o_ready, 1'b0);
    do_reset();
    directed(32'hFE000CE3, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0);

    for (int k = 0; k < 3000; k++) begin
      r = $urandom;
      if ($urandom_range(0, 9) < 8) r[6:0] = OPS[$urandom_range(0, 10)];
      cycle($urandom_range(0, 3) != 0, r, $urandom_range(0, 2) != 0);
    end
    for (int k = 0; k < 4; k++) cycle(1'b0, 32'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
